// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: TXDATA push port, STATUS register, TX FIFO and 8N1 shifter.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_mmio #(
    parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wren,
    output logic [31:0] rdata,
    output logic        tx,
    output logic        irq_empty
);

    localparam int          AW          = $clog2(FIFO_DEPTH);
    localparam int          CW          = AW + 1;
    localparam logic [31:0] STATUS_ADDR = BASE_ADDR + 32'd4;
    localparam logic [15:0] BIT_LOAD    = 16'(CLKS_PER_BIT - 1);
`ifdef UART_TX_PARITY_EN
    localparam logic        PAR_EN      = 1'b1;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    localparam logic        PAR_EN      = 1'b0;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t         state, state_next;
    logic [15:0]    timer, timer_next;
    logic [2:0]     bit_cnt, bit_cnt_next;
    logic [7:0]     shreg, shreg_next;
    logic           par, par_next;
    logic           tx_next;

    logic [7:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count, count_next;
    logic           overflow;
    logic           full, empty, push_req, push, pop, ovf_set, ovf_clr;
    logic [7:0]     head;
    logic           unused_bits;

    assign unused_bits = ^{wdata[31:8], wren[3:1]};

    assign full     = (count == CW'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign head     = mem[rd_ptr];
    assign push_req = (addr == BASE_ADDR) && wren[0];
    // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
    assign push     = push_req && (!full || pop);
    assign ovf_set  = push_req && full && !pop;
    assign ovf_clr  = (addr == STATUS_ADDR) && wren[0] && wdata[3];

    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + CW'(1);
        else if (pop && !push)
            count_next = count - CW'(1);
    end

    always_comb begin
        state_next   = state;
        timer_next   = timer;
        bit_cnt_next = bit_cnt;
        shreg_next   = shreg;
        par_next     = par;
        tx_next      = tx;
        pop          = 1'b0;
        case (state)
            IDLE: begin
                tx_next = 1'b1;
                if (!empty) begin
                    pop        = 1'b1;
                    shreg_next = head;
                    par_next   = ^head;
                    timer_next = BIT_LOAD;
                    state_next = START;
                    tx_next    = 1'b0;
                end
            end
            START: begin
                if (timer == '0) begin
                    state_next   = DATA;
                    timer_next   = BIT_LOAD;
                    bit_cnt_next = '0;
                    tx_next      = shreg[0];
                end else begin
                    timer_next = timer - 16'd1;
                end
            end
            DATA: begin
                if (timer == '0) begin
                    timer_next   = BIT_LOAD;
                    bit_cnt_next = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_next = PARITY;
                        tx_next    = par;
`else
                        state_next = STOP;
                        tx_next    = 1'b1;
`endif
                    end else begin
                        shreg_next = shreg >> 1;
                        tx_next    = shreg[1];
                    end
                end else begin
                    timer_next = timer - 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (timer == '0) begin
                    state_next = STOP;
                    timer_next = BIT_LOAD;
                    tx_next    = 1'b1;
                end else begin
                    timer_next = timer - 16'd1;
                end
            end
`endif
            STOP: begin
                if (timer == '0) begin
                    // Chain straight into the next start bit when data is waiting.
                    if (!empty) begin
                        pop        = 1'b1;
                        shreg_next = head;
                        par_next   = ^head;
                        timer_next = BIT_LOAD;
                        state_next = START;
                        tx_next    = 1'b0;
                    end else begin
                        state_next = IDLE;
                        tx_next    = 1'b1;
                    end
                end else begin
                    timer_next = timer - 16'd1;
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            timer     <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            par       <= 1'b0;
            tx        <= 1'b1;
            irq_empty <= 1'b1;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_next;
            timer     <= timer_next;
            bit_cnt   <= bit_cnt_next;
            shreg     <= shreg_next;
            par       <= par_next;
            tx        <= tx_next;
            irq_empty <= (count_next == '0) && (state_next == IDLE);
            count     <= count_next;
            overflow  <= ovf_set | (overflow & ~ovf_clr);
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push)
            mem[wr_ptr] <= wdata[7:0];
    end

    always_comb begin
        rdata = '0;
        if (addr == STATUS_ADDR) begin
            rdata[0]      = full;
            rdata[1]      = empty;
            rdata[2]      = (state != IDLE);
            rdata[3]      = overflow;
            rdata[4]      = PAR_EN;
            rdata[8 +: CW] = count;
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio at CLKS_PER_BIT=4, FIFO_DEPTH=8; follows UART_TX_PARITY_EN if defined.
module tb_uart_tx_mmio;

    localparam int          CPB    = 4;
    localparam logic [31:0] BASE   = 32'hFFFF_0000;
    localparam logic [31:0] STAT   = 32'hFFFF_0004;
`ifdef UART_TX_PARITY_EN
    localparam logic [31:0] PB     = 32'h10;
    localparam int          NBITS  = 11;
`else
    localparam logic [31:0] PB     = 32'h0;
    localparam int          NBITS  = 10;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  wren;
    logic        tx, irq_empty;

    int compared   = 0;
    int mismatched = 0;

    uart_tx_mmio #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .wren(wren),
        .rdata(rdata), .tx(tx), .irq_empty(irq_empty)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_status(input string tag, input logic [31:0] exp);
        addr = STAT;
        wren = 4'b0000;
        #1;
        chk(tag, rdata, exp);
    endtask

    task automatic push(input logic [7:0] b);
        addr  = BASE;
        wdata = {24'hABCDEF, b};
        wren  = 4'b0001;
        tick();
        wren  = 4'b0000;
    endtask

    // Starts at a sample point inside a frame (index skip) and stops at its last sample.
    task automatic expect_frame(input logic [7:0] d, input int skip);
        logic [10:0] fb;
        fb      = '1;
        fb[0]   = 1'b0;
        fb[8:1] = d;
`ifdef UART_TX_PARITY_EN
        fb[9]   = ^d;
`endif
        for (int k = skip; k < NBITS * CPB; k++) begin
            chk($sformatf("frame_%02h_s%0d", d, k), {31'b0, tx}, {31'b0, fb[k / CPB]});
            if (k == CPB * 5)
                chk($sformatf("irq_mid_%02h", d), {31'b0, irq_empty}, 32'd0);
            if (k < NBITS * CPB - 1)
                tick();
        end
    endtask

    initial begin
        logic saw_low;
        rst = 1'b1; addr = '0; wdata = '0; wren = '0;
        tick(); tick();
        rst = 1'b0;

        chk("reset_tx", {31'b0, tx}, 32'd1);
        chk("reset_irq", {31'b0, irq_empty}, 32'd1);
        chk_status("reset_status", 32'h2 | PB);
        addr = BASE; #1;
        chk("txdata_read", rdata, 32'h0);
        addr = BASE + 32'd8; #1;
        chk("unmapped_read", rdata, 32'h0);

        addr = BASE; wdata = 32'h55; wren = 4'b1110;
        tick();
        wren = 4'b0000;
        chk_status("upper_wren_nopush", 32'h2 | PB);
        chk("upper_wren_tx", {31'b0, tx}, 32'd1);

        // single frame 0x55, start bit one edge after the push
        push(8'h55);
        chk("push_tx_still_idle", {31'b0, tx}, 32'd1);
        chk_status("push_status", 32'h100 | PB);
        tick();
        expect_frame(8'h55, 0);
        tick();
        chk("after_55_irq", {31'b0, irq_empty}, 32'd1);
        chk("after_55_tx", {31'b0, tx}, 32'd1);
        chk_status("after_55_status", 32'h2 | PB);

        push(8'h07);
        tick();
        expect_frame(8'h07, 0);
        tick();
        chk("after_07_irq", {31'b0, irq_empty}, 32'd1);

        // back-to-back 0x01, 0x80
        push(8'h01);
        push(8'h80);
        chk_status("b2b_count1", 32'h104 | PB);
        expect_frame(8'h01, 0);
        tick();
        chk_status("b2b_count0", 32'h006 | PB);
        expect_frame(8'h80, 0);
        tick();
        chk("b2b_irq", {31'b0, irq_empty}, 32'd1);
        chk_status("b2b_idle", 32'h2 | PB);

        // overflow: ten pushes, the tenth dropped
        for (int i = 0; i < 10; i++)
            push(8'(i));
        chk_status("ovf_full", 32'h80D | PB);
        expect_frame(8'h00, 8);
        for (int i = 1; i < 9; i++) begin
            tick();
            expect_frame(8'(i), 0);
        end
        tick();
        chk("ovf_drain_irq", {31'b0, irq_empty}, 32'd1);
        chk_status("ovf_sticky", 32'h00A | PB);
        addr = STAT; wdata = 32'h8; wren = 4'b0001;
        tick();
        wren = 4'b0000;
        chk_status("ovf_cleared", 32'h2 | PB);

        // push into full FIFO on the same edge as a pop
        for (int i = 0; i < 9; i++)
            push(8'(8'h10 + i));
        chk_status("fullpop_pre", 32'h805 | PB);
        expect_frame(8'h10, 7);
        addr = BASE; wdata = 32'h99; wren = 4'b0001;
        tick();
        wren = 4'b0000;
        chk_status("fullpop_post", 32'h805 | PB);
        for (int i = 1; i < 9; i++) begin
            expect_frame(8'(8'h10 + i), 0);
            tick();
        end
        expect_frame(8'h99, 0);
        tick();
        chk("fullpop_irq", {31'b0, irq_empty}, 32'd1);
        chk_status("fullpop_idle", 32'h2 | PB);

        // reset mid-frame, with a push on the reset edge
        push(8'h55);
        tick();
        for (int i = 0; i < 17; i++)
            tick();
        chk("midframe_tx_low", {31'b0, tx}, 32'd0);
        rst = 1'b1; addr = BASE; wdata = 32'hAA; wren = 4'b0001;
        tick();
        rst = 1'b0; wren = 4'b0000;
        chk("rst_tx", {31'b0, tx}, 32'd1);
        chk("rst_irq", {31'b0, irq_empty}, 32'd1);
        chk_status("rst_status", 32'h2 | PB);
        saw_low = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (tx !== 1'b1)
                saw_low = 1'b1;
        end
        chk("rst_no_resume", {31'b0, saw_low}, 32'd0);
        chk_status("rst_status_late", 32'h2 | PB);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/uart_tx_mmio.md
UART_TX_MMIO -- requirements
Module: uart_tx_mmio

Interface
REQ-001 Parameter BASE_ADDR, default 32'hFFFF_0000, word address of TXDATA; STATUS sits at BASE_ADDR+4.
REQ-002 Parameter CLKS_PER_BIT, default 16, clock cycles per serial bit; legal range 2..65535.
REQ-003 Parameter FIFO_DEPTH, default 8, TX FIFO entries; power of two, 2..64.
REQ-004 clk  input  1  system clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 addr  input  32  CPU data address (ALU result), shared with data memory.
REQ-007 wdata  input  32  CPU store data (register file rdata1).
REQ-008 wren  input  4  per-byte store enables, same encoding as data memory wren.
REQ-009 rdata  output  32  combinational read data for addr; 0 when addr matches neither register.
REQ-010 tx  output  1  registered serial line, idle high.
REQ-011 irq_empty  output  1  registered; high when FIFO empty and shifter idle.

Function
REQ-012 Push: a rising edge with addr==BASE_ADDR and wren[0]==1 shall write wdata[7:0] to the FIFO tail. wren[3:1] are ignored.
REQ-013 Push while FIFO full shall drop the byte, leave FIFO unchanged, and set sticky overflow.
REQ-014 Write to STATUS with wren[0]==1 and wdata[3]==1 shall clear overflow. Other STATUS bits are read-only.
REQ-015 STATUS read value: bit0 full; bit1 empty; bit2 busy (FSM not IDLE); bit3 overflow; bits[14:8] FIFO count; all other bits 0.
REQ-016 TXDATA read value: 0.
REQ-017 FSM states: IDLE, START, DATA, PARITY (present only when the macro is defined), STOP.
REQ-018 IDLE with FIFO non-empty: on the next edge, pop the head into the shift register, enter START, and drive tx=0.
REQ-019 START, DATA and STOP shall each hold for exactly CLKS_PER_BIT cycles, counted by a bit-timer that reloads at each state or bit change.
REQ-020 DATA shall shift 8 bits, LSB first; a 3-bit counter wraps 7->0 to exit to PARITY or STOP.
REQ-021 STOP shall drive tx=1. On exit:
  - FIFO non-empty: pop and enter START directly, giving back-to-back frames with no idle bit.
  - FIFO empty: enter IDLE.
REQ-022 Latency: a push at edge N to an empty, idle block shall drive tx low at edge N+1.
REQ-023 Simultaneous push and pop with the FIFO full shall accept the push; count is unchanged.
REQ-024 Simultaneous push and pop with the FIFO empty shall not occur, because a pop requires count>0 before the edge.
REQ-025 FIFO pointers shall wrap modulo FIFO_DEPTH; count width is log2(FIFO_DEPTH)+1.

Reset
REQ-026 rst high at an edge shall force:
  - FSM to IDLE, tx=1, irq_empty=1;
  - FIFO pointers and count to 0, overflow=0;
  - bit-timer and bit counter to 0.
REQ-027 rst asserted mid-frame shall abort the frame immediately; tx returns high at that edge and no partial byte is resumed.
REQ-028 A push coinciding with rst shall be discarded.

Configuration
REQ-029 Macro UART_TX_PARITY_EN defined: an even-parity bit (XOR of the 8 data bits) is sent for CLKS_PER_BIT cycles between DATA and STOP, and STATUS bit4 reads 1.
REQ-030 Macro UART_TX_PARITY_EN undefined: no PARITY state, DATA proceeds to STOP, and STATUS bit4 reads 0.

Verification
REQ-031 CLKS_PER_BIT=4, no parity, push 0x55 -> tx sequence 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles, 40 cycles total, then irq_empty=1.
REQ-032 Push 0x01 then 0x80 on consecutive cycles -> two 40-cycle frames with no idle gap; STATUS count 1 after edge 2, 0 after the second pop.
REQ-033 10 consecutive pushes 0x00..0x09 starting idle -> 0x00..0x08 transmitted in order, 0x09 dropped, STATUS bit3=1; a STATUS write of 0x8 then clears bit3.
REQ-034 rst asserted during bit 3 of the 0x55 frame -> tx=1 at that edge, STATUS reads 0x0000_0002, and no further frame is sent.
REQ-035 UART_TX_PARITY_EN defined, push 0x07 -> parity bit 1 appears after data bit 7; frame length 44 cycles.
REQ-036 Read addr=BASE_ADDR+8 -> rdata=0; store with wren=4'b1110 to BASE_ADDR -> no push.
